pipe_series_eval: RTL

Registered, parametrised successor to the combinational series slice. It evaluates a truncated power series in signed Q1.(W-1) fixed point: out_sum = in_sum0 + Σ_{k<n} C[k]·x^(k+1). The evaluator is built from NTERMS register-separated stages and uses valid/ready flow control. It sits between the sample source and the result consumer in the series datapath, and adds a per-sample runtime term count, saturating or wrapping overflow handling, and back-pressure.

---
 rtl/series_pkg.sv | 46 ++++
 rtl/pipe_series_eval_if.sv | 25 ++
 rtl/pipe_series_stage.sv | 81 ++++++++
 rtl/pipe_series_eval.sv | 71 +++++++
 4 files changed

// File: rtl/series_pkg.sv
// Q1.(w-1) fixed-point helpers shared by the series pipeline.
// Values travel sign-extended to MAXW bits, so one set of functions covers any W < MAXW.
package series_pkg;

    localparam int MAXW = 64;

    typedef logic signed [MAXW-1:0] qword_t;

    typedef struct packed {
        logic   ovf;
        qword_t val;
    } qres_t;

    function automatic qword_t qmax(input int w);
        return (qword_t'(1) <<< (w - 1)) - qword_t'(1);
    endfunction

    function automatic qword_t qmin(input int w);
        return ~qmax(w);
    endfunction

    // Keep the low w bits and re-extend their sign through the full word.
    function automatic qword_t sext(input qword_t v, input int w);
        return (v <<< (MAXW - w)) >>> (MAXW - w);
    endfunction

    function automatic qres_t sat_add(input qword_t a, input qword_t b, input int w, input logic sat);
        qres_t  r;
        qword_t s;
        s     = sext(a + b, w);
        r.ovf = (a[MAXW-1] == b[MAXW-1]) && (s[MAXW-1] != a[MAXW-1]);
        r.val = (r.ovf && sat) ? (a[MAXW-1] ? qmin(w) : qmax(w)) : s;
        return r;
    endfunction

    // Truncating product; only (-1.0)*(-1.0) falls outside the format.
    function automatic qres_t q_mul(input qword_t a, input qword_t b, input int w, input logic sat);
        logic [2*MAXW-1:0] p;
        qres_t             r;
        p     = {{MAXW{a[MAXW-1]}}, a} * {{MAXW{b[MAXW-1]}}, b};
        r.ovf = (a == qmin(w)) && (b == qmin(w));
        r.val = (r.ovf && sat) ? qmax(w) : sext(qword_t'(p >> (w - 1)), w);
        return r;
    endfunction

endpackage

// File: rtl/pipe_series_eval_if.sv
// Sample-in / result-out handshake bundle for the series evaluator.
interface pipe_series_eval_if #(
    parameter int W  = 32,
    parameter int CW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_sum0;
    logic [CW-1:0] in_n;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_ovf;

    modport master (
        output in_valid, in_x, in_sum0, in_n, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_x, in_sum0, in_n, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/pipe_series_stage.sv
// One series term: raises the running power of x, adds C[K]*x^(K+1) into the sum.
// Stages at or beyond the sample's term count pass their bundle through untouched.
module pipe_series_stage
    import series_pkg::*;
#(
    parameter int           W        = 32,
    parameter int           CW       = 4,
    parameter int           K        = 0,
    parameter logic [W-1:0] COEF     = '0,
    parameter bit           SATURATE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic          src_valid,
    input  logic [W-1:0]  src_x,
    input  logic [W-1:0]  src_num,
    input  logic [W-1:0]  src_sum,
    input  logic [CW-1:0] src_n,
    input  logic          src_ovf,
    output logic          valid,
    output logic [W-1:0]  x,
    output logic [W-1:0]  num,
    output logic [W-1:0]  sum,
    output logic [CW-1:0] n,
    output logic          ovf
);

    localparam logic [CW-1:0] KC = CW'(K);

    function automatic qword_t ext(input logic [W-1:0] v);
        return qword_t'(signed'(v));
    endfunction

    logic  active;
    qres_t m_pow, m_term, a_sum;
    logic  unused_hi;

    always_comb begin
        active = KC < src_n;
        // Stage 0 already holds x^1, so it skips the power multiply.
        if (K == 0) begin
            m_pow.ovf = 1'b0;
            m_pow.val = ext(src_num);
        end else begin
            m_pow = q_mul(ext(src_num), ext(src_x), W, SATURATE);
        end
        m_term = q_mul(ext(COEF), m_pow.val, W, SATURATE);
        a_sum  = sat_add(ext(src_sum), m_term.val, W, SATURATE);
    end

    assign unused_hi = ^{m_pow.val[MAXW-1:W], m_term.val[MAXW-1:W], a_sum.val[MAXW-1:W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            x     <= '0;
            num   <= '0;
            sum   <= '0;
            n     <= '0;
            ovf   <= 1'b0;
        end else if (adv) begin
            valid <= src_valid;
            // Data only moves with a real sample so the tail holds its last result.
            if (src_valid) begin
                x <= src_x;
                n <= src_n;
                if (active) begin
                    num <= m_pow.val[W-1:0];
                    sum <= a_sum.val[W-1:0];
                    ovf <= src_ovf | m_pow.ovf | m_term.ovf | a_sum.ovf;
                end else begin
                    num <= src_num;
                    sum <= src_sum;
                    ovf <= src_ovf;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_series_eval.sv
// Registered power-series evaluator: NTERMS stages advancing together under valid/ready.
// The whole pipe stalls as one unit whenever a result is waiting and the consumer is not ready.
module pipe_series_eval
    import series_pkg::*;
#(
    parameter int                  W        = 32,
    parameter int                  NTERMS   = 8,
    parameter logic [NTERMS*W-1:0] COEFS    = '0,
    parameter bit                  SATURATE = 1'b1,
    parameter int                  CW       = $clog2(NTERMS + 1)
) (
    input logic                clk,
    input logic                rst,
    pipe_series_eval_if.slave  bus
);

    localparam logic [CW-1:0] NMAX = CW'(NTERMS);

    logic                       adv;
    logic [NTERMS:0]            valid;
    logic [NTERMS:0]            ovf;
    logic [NTERMS:0][W-1:0]     x;
    logic [NTERMS:0][W-1:0]     num;
    logic [NTERMS:0][W-1:0]     sum;
    logic [NTERMS:0][CW-1:0]    n;
    logic                       unused_tail;

    assign adv          = !valid[NTERMS] || bus.out_ready;
    assign bus.in_ready = adv;

    // Slot 0 is the incoming sample; the term count is clamped once here.
    assign valid[0] = bus.in_valid;
    assign x[0]     = bus.in_x;
    assign num[0]   = bus.in_x;
    assign sum[0]   = bus.in_sum0;
    assign n[0]     = (bus.in_n > NMAX) ? NMAX : bus.in_n;
    assign ovf[0]   = 1'b0;

    for (genvar k = 0; k < NTERMS; k++) begin : g_stage
        pipe_series_stage #(
            .W        (W),
            .CW       (CW),
            .K        (k),
            .COEF     (COEFS[k*W +: W]),
            .SATURATE (SATURATE)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .src_valid (valid[k]),
            .src_x     (x[k]),
            .src_num   (num[k]),
            .src_sum   (sum[k]),
            .src_n     (n[k]),
            .src_ovf   (ovf[k]),
            .valid     (valid[k+1]),
            .x         (x[k+1]),
            .num       (num[k+1]),
            .sum       (sum[k+1]),
            .n         (n[k+1]),
            .ovf       (ovf[k+1])
        );
    end

    assign bus.out_valid = valid[NTERMS];
    assign bus.out_sum   = sum[NTERMS];
    assign bus.out_ovf   = ovf[NTERMS];

    assign unused_tail = ^{x[NTERMS], num[NTERMS], n[NTERMS]};

endmodule
